// File: rtl/calc_datapath.sv
// Calculator datapath: operand registers A/B, operand mux, 2-bit-op ALU and the
// shiftable accumulator C, plus a result register captured on the rising edge of fim.
module calc_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             enA,
  input  logic             enB,
  input  logic             sel,
  input  logic [1:0]       op,
  input  logic [1:0]       op_Reg,
  input  logic             fim,
  output logic [WIDTH-1:0] result,
  output logic             result_carry,
  output logic             result_valid,
  output logic [WIDTH-1:0] acc
);

  typedef enum logic [1:0] {OP_PASS, OP_ADD, OP_SUB, OP_NOT} alu_op_t;
  typedef enum logic [1:0] {C_HOLD, C_LOAD, C_SHR, C_SHL} c_op_t;

  alu_op_t          alu_op;
  c_op_t            c_op;
  logic [WIDTH-1:0] a, b, c, x, y;
  logic [WIDTH:0]   sum, diff;
  logic             cout, cf, fim_q, fim_rise;

  assign alu_op   = alu_op_t'(op);
  assign c_op     = c_op_t'(op_Reg);
  assign x        = sel ? c : b;
  assign acc      = c;
  assign fim_rise = fim && !fim_q;

  // One extra bit carries the adder's carry-out and the subtractor's borrow.
  assign sum  = {1'b0, a} + {1'b0, x};
  assign diff = {1'b0, a} - {1'b0, x};

  always_comb begin
    // NOTE: every output gets a default first, so no case path can infer a latch.
    y    = a;
    cout = 1'b0;
    case (alu_op)
      OP_ADD: {cout, y} = sum;
      OP_SUB: begin
        y    = diff[WIDTH-1:0];
        cout = diff[WIDTH];
      end
      OP_NOT: y = ~a;
      default: ;
    endcase
  end

  // NOTE: non-blocking assignments make every read below see pre-edge values,
  // which is exactly the read-before-write behaviour the controller relies on.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a            <= '0;
      b            <= '0;
      c            <= '0;
      cf           <= 1'b0;
      fim_q        <= 1'b0;
      result       <= '0;
      result_carry <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      if (enA) a <= data_in;
      if (enB) b <= data_in;

      case (c_op)
        C_LOAD: c <= y;
        C_SHR:  c <= {1'b0, c[WIDTH-1:1]};
        C_SHL:  c <= {c[WIDTH-2:0], 1'b0};
        default: ;
      endcase

      // Loading A starts a new computation, so its clear beats any carry set.
      if (enA)
        cf <= 1'b0;
      else if (c_op == C_LOAD && (alu_op == OP_ADD || alu_op == OP_SUB) && cout)
        cf <= 1'b1;

      fim_q        <= fim;
      result_valid <= fim_rise;
      if (fim_rise) begin
        result       <= c;
        result_carry <= cf;
      end
    end
  end

endmodule
